// File: rtl/mem_access_stage.sv
// MEM stage: drives a single-beat data memory port, aligns store lanes, extends
// load data and resolves branches; stalls upstream while a memory access is open.
module mem_access_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  WB_control_MEM,
   input  logic [2:0]  MEM_control_MEM,
   input  logic [63:0] branch_addr_MEM,
   input  logic [63:0] alu_result_MEM,
   input  logic        zero_MEM,
   input  logic        less_MEM,
   input  logic [63:0] read_data2_MEM,
   input  logic [4:0]  rd_MEM,
   input  logic [2:0]  funct3_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic [63:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        pc_src,
   output logic [63:0] branch_target,
   output logic        misalign,
   output logic [1:0]  WB_control_WB,
   output logic [63:0] read_data_WB,
   output logic [63:0] alu_result_WB,
   output logic [4:0]  rd_WB
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0] state;
   logic [2:0] off_p0;
   logic [2:0] f3_p0;
   logic       branch, mem_write, mem_op, misaligned;
   logic [2:0] off;

   function automatic logic [7:0] strobe_base(input logic [1:0] size);
      case (size)
         2'd0:    strobe_base = 8'h01;
         2'd1:    strobe_base = 8'h03;
         2'd2:    strobe_base = 8'h0F;
         default: strobe_base = 8'hFF;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
      case (size)
         2'd0:    is_misaligned = 1'b0;
         2'd1:    is_misaligned = low[0];
         2'd2:    is_misaligned = |low[1:0];
         default: is_misaligned = |low;
      endcase
   endfunction

   function automatic logic branch_cond(input logic [2:0] f3, input logic z, input logic lt);
      case (f3)
         3'b000:  branch_cond = z;
         3'b001:  branch_cond = ~z;
         3'b100:  branch_cond = lt;
         3'b101:  branch_cond = ~lt;
         default: branch_cond = 1'b0;
      endcase
   endfunction

   // Raw is already shifted so the addressed byte sits in bits [7:0].
   function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] f3);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      logic signed [63:0] ext;
      b = raw[7:0];
      h = raw[15:0];
      w = raw[31:0];
      case (f3)
         3'b000:  ext = 64'(b);
         3'b001:  ext = 64'(h);
         3'b010:  ext = 64'(w);
         3'b100:  ext = 64'(raw[7:0]);
         3'b101:  ext = 64'(raw[15:0]);
         3'b110:  ext = 64'(raw[31:0]);
         default: ext = raw;
      endcase
      load_extend = ext;
   endfunction

   assign branch        = MEM_control_MEM[2];
   assign mem_write     = MEM_control_MEM[0];
   assign mem_op        = MEM_control_MEM[1] | MEM_control_MEM[0];
   assign off           = alu_result_MEM[2:0];
   assign misaligned    = is_misaligned(funct3_MEM[1:0], off);
   assign pc_src        = branch & branch_cond(funct3_MEM, zero_MEM, less_MEM);
   assign branch_target = branch_addr_MEM;
   assign dmem_req      = (state == BUSY);

   always_comb begin
      stall = 1'b0;
      if (state == BUSY) stall = ~dmem_ack;
      else               stall = mem_op & ~misaligned;
   end

   // Lane offset and load kind captured at request time for the response
   always_ff @(posedge clk) begin
      if (state == IDLE && mem_op && !misaligned) begin
         off_p0 <= off;
         f3_p0  <= funct3_MEM;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_wstrb    <= '0;
         misalign      <= 1'b0;
         WB_control_WB <= '0;
         read_data_WB  <= '0;
         alu_result_WB <= '0;
         rd_WB         <= '0;
      end else if (state == IDLE) begin
         if (mem_op && !misaligned) begin
            state         <= BUSY;
            dmem_we       <= mem_write;
            dmem_addr     <= {alu_result_MEM[63:3], 3'b000};
            dmem_wstrb    <= mem_write ? (strobe_base(funct3_MEM[1:0]) << off) : 8'h00;
            dmem_wdata    <= read_data2_MEM << {off, 3'b000};
            misalign      <= 1'b0;
            WB_control_WB <= 2'b00;
         end else begin
            misalign      <= mem_op;
            WB_control_WB <= mem_op ? 2'b00 : WB_control_MEM;
            alu_result_WB <= alu_result_MEM;
            rd_WB         <= rd_MEM;
         end
      end else begin
         misalign <= 1'b0;
         if (dmem_ack) begin
            state         <= IDLE;
            dmem_we       <= 1'b0;
            dmem_wstrb    <= 8'h00;
            WB_control_WB <= WB_control_MEM;
            alu_result_WB <= alu_result_MEM;
            rd_WB         <= rd_MEM;
            read_data_WB  <= dmem_we ? 64'd0
                                     : load_extend(dmem_rdata >> {off_p0, 3'b000}, f3_p0);
         end else begin
            WB_control_WB <= 2'b00;
         end
      end
   end

endmodule
